// File: rtl/sigmul_seq_if.sv
// Handshake and data bundle between the FP preprocess stage and
// the sequential significand multiplier.
interface sigmul_seq_if #(
  parameter int WIDTH = 32,
  parameter int WEXP  = 8,
  parameter int WSIG  = 23
);
  logic                  start;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  zero;
  logic                  infinity;
  logic                  aisnan;
  logic                  bisnan;
  logic                  aisdenorm;
  logic                  bisdenorm;
  logic                  sign;
  logic [1:0]            roundmode;
  logic                  busy;
  logic                  done;
  logic [2*WSIG+1:0]     prod;
  logic [WEXP+1:0]       expsum;
  logic [1:0]            special;
  logic                  sign_o;
  logic [1:0]            roundmode_o;

  modport master (
    output start, a, b,
    output zero, infinity,
    output aisnan, bisnan,
    output aisdenorm, bisdenorm,
    output sign, roundmode,
    input  busy, done, prod,
    input  expsum, special,
    input  sign_o, roundmode_o
  );

  modport slave (
    input  start, a, b,
    input  zero, infinity,
    input  aisnan, bisnan,
    input  aisdenorm, bisdenorm,
    input  sign, roundmode,
    output busy, done, prod,
    output expsum, special,
    output sign_o, roundmode_o
  );
endinterface

// File: rtl/sigmul_seq.sv
// Sequential radix-2 shift-add significand multiplier with
// exponent sum and special-case classification.
module sigmul_seq #(
  parameter int WIDTH = 32,
  parameter int WEXP  = 8,
  parameter int WSIG  = 23
) (
  input logic        clk,
  input logic        rst,
  sigmul_seq_if.slave bus
);
  localparam int WM = WSIG + 1;
  localparam int WP = 2 * WSIG + 2;
  localparam int WE = WEXP + 2;
  localparam int WC = $clog2(WM + 1);
  localparam logic [WE-1:0] BIAS =
    WE'((1 << (WEXP - 1)) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WC-1:0]   cnt;
  logic [WP-1:0]   acc;
  logic [WM-1:0]   mc;
  logic            busy_q;
  logic            done_q;
  logic [WP-1:0]   prod_q;
  logic [WE-1:0]   exps_q;
  logic [1:0]      spec_q;
  logic            sign_q;
  logic [1:0]      rm_q;

  logic [WM-1:0]   siga;
  logic [WM-1:0]   sigb;
  logic [WE-1:0]   ea;
  logic [WE-1:0]   eb;
  logic [WE-1:0]   esum;
  logic            nan;
  logic [1:0]      cls;
  logic [WM:0]     sum;
  logic [WP-1:0]   accn;
  logic            unused_signs;

  assign unused_signs =
    ^{bus.a[WIDTH-1], bus.b[WIDTH-1]};

  assign siga = {~bus.aisdenorm, bus.a[WSIG-1:0]};
  assign sigb = {~bus.bisdenorm, bus.b[WSIG-1:0]};

  assign ea = bus.aisdenorm ? WE'(1) :
    WE'(bus.a[WSIG+WEXP-1:WSIG]);
  assign eb = bus.bisdenorm ? WE'(1) :
    WE'(bus.b[WSIG+WEXP-1:WSIG]);
  assign esum = ea + eb - BIAS;

  assign nan = bus.aisnan | bus.bisnan |
    (bus.infinity & bus.zero);

  always_comb begin
    cls = 2'b00;
    priority case (1'b1)
      nan:          cls = 2'b11;
      bus.infinity: cls = 2'b10;
      bus.zero:     cls = 2'b01;
      default:      cls = 2'b00;
    endcase
  end

  // Upper half accumulates, lower half holds the
  // unconsumed multiplier bits; shift right each step.
  assign sum = {1'b0, acc[WP-1:WM]} +
    (acc[0] ? {1'b0, mc} : '0);
  assign accn = {sum, acc[WM-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mc     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      prod_q <= '0;
      exps_q <= '0;
      spec_q <= 2'b00;
      sign_q <= 1'b0;
      rm_q   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            sign_q <= bus.sign;
            rm_q   <= bus.roundmode;
            spec_q <= cls;
            if (cls != 2'b00) begin
              prod_q <= '0;
              exps_q <= '0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              exps_q <= esum;
              mc     <= siga;
              acc    <= {{WM{1'b0}}, sigb};
              cnt    <= WC'(WM);
              state  <= MUL;
            end
          end
        end
        MUL: begin
          acc <= accn;
          cnt <= cnt - WC'(1);
          if (cnt == WC'(1)) begin
            prod_q <= accn;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.prod        = prod_q;
  assign bus.expsum      = exps_q;
  assign bus.special     = spec_q;
  assign bus.sign_o      = sign_q;
  assign bus.roundmode_o = rm_q;
endmodule

// File: tb/tb_sigmul_seq.sv
// Scoreboard bench for sigmul_seq: directed vectors, random
// normal operands, reset abort, ignored and back-to-back starts.
module tb_sigmul_seq;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sigmul_seq_if #(.WIDTH(32), .WEXP(8), .WSIG(23)) bus();

  sigmul_seq #(.WIDTH(32), .WEXP(8), .WSIG(23)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [47:0] prod;
    logic [9:0]  es;
    logic [1:0]  sp;
    logic        sg;
    logic [1:0]  rm;
    int          dc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t last;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("prod", 64'(bus.prod), 64'(mon_e.prod));
        check("expsum", 64'(bus.expsum), 64'(mon_e.es));
        check("special", 64'(bus.special), 64'(mon_e.sp));
        check("sign_o", 64'(bus.sign_o), 64'(mon_e.sg));
        check("rm_o", 64'(bus.roundmode_o), 64'(mon_e.rm));
        check("latency", 64'(cyc), 64'(mon_e.dc));
        check("busy_in_done", 64'(bus.busy), 64'd1);
        last = mon_e;
      end
    end
  end

  // fl = {zero, infinity, aisnan, bisnan, aisdenorm, bisdenorm, sign}
  task automatic drive(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [6:0] fl,
                       input logic [1:0] rm);
    bus.a         = a;
    bus.b         = b;
    bus.zero      = fl[6];
    bus.infinity  = fl[5];
    bus.aisnan    = fl[4];
    bus.bisnan    = fl[3];
    bus.aisdenorm = fl[2];
    bus.bisdenorm = fl[1];
    bus.sign      = fl[0];
    bus.roundmode = rm;
  endtask

  task automatic launch(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [6:0] fl,
                        input logic [1:0] rm,
                        input logic [47:0] ep,
                        input logic [9:0] ee,
                        input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    drive(a, b, fl, rm);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e.prod = ep;
    e.es   = ee;
    e.sp   = es;
    e.sg   = fl[0];
    e.rm   = rm;
    e.dc   = cyc + ((es == 2'b00) ? 24 : 0);
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0)
      check("timeout", 64'(bus.busy), 64'd0);
    @(negedge clk);
  endtask

  function automatic void model(input logic [31:0] a,
                                input logic [31:0] b,
                                input logic ad,
                                input logic bd,
                                output logic [47:0] p,
                                output logic [9:0] e);
    logic [47:0] sa;
    logic [47:0] sb;
    logic [9:0]  xa;
    logic [9:0]  xb;
    sa = {24'd0, ~ad, a[22:0]};
    sb = {24'd0, ~bd, b[22:0]};
    xa = ad ? 10'd1 : {2'b00, a[30:23]};
    xb = bd ? 10'd1 : {2'b00, b[30:23]};
    p  = sa * sb;
    e  = xa + xb - 10'd127;
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [6:0]  rf;
    logic [1:0]  rr;
    logic [47:0] mp;
    logic [9:0]  me;
    exp_t e;
    int   c1;

    rst = 1'b1;
    bus.start = 1'b0;
    drive(32'd0, 32'd0, 7'd0, 2'd0);
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod", 64'(bus.prod), 64'd0);
    check("rst_expsum", 64'(bus.expsum), 64'd0);
    check("rst_special", 64'(bus.special), 64'd0);
    check("rst_sign", 64'(bus.sign_o), 64'd0);
    check("rst_rm", 64'(bus.roundmode_o), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    launch(32'h3F800000, 32'h3F800000, 7'b0, 2'd0,
           48'h4000_0000_0000, 10'd127, 2'b00);
    wait_idle();
    launch(32'h3FC00000, 32'h40000000, 7'b0, 2'd1,
           48'h6000_0000_0000, 10'd128, 2'b00);
    wait_idle();
    launch(32'h00000000, 32'h7F800000, 7'b1100001, 2'd2,
           48'h0, 10'd0, 2'b11);
    wait_idle();
    launch(32'h00000001, 32'h3F800000, 7'b0000100, 2'd3,
           48'h0000_0080_0000, 10'd1, 2'b00);
    wait_idle();
    launch(32'h7F800000, 32'h3F800000, 7'b0100001, 2'd3,
           48'h0, 10'd0, 2'b10);
    wait_idle();
    launch(32'h00000000, 32'h3F800000, 7'b1000000, 2'd1,
           48'h0, 10'd0, 2'b01);
    wait_idle();
    launch(32'h7FC00000, 32'h00000000, 7'b1010000, 2'd0,
           48'h0, 10'd0, 2'b11);
    wait_idle();

    // outputs hold after done while inputs wander
    drive(32'h12345678, 32'h9ABCDEF0, 7'b0, 2'd2);
    repeat (3) @(negedge clk);
    check("hold_prod", 64'(bus.prod), 64'(last.prod));
    check("hold_special", 64'(bus.special), 64'(last.sp));

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = {4'b0000, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom)};
      rr = 2'($urandom);
      model(ra, rb, rf[2], rf[1], mp, me);
      launch(ra, rb, rf, rr, mp, me, 2'b00);
      wait_idle();
    end

    // reset mid-multiply abandons the op
    launch(32'h3FC00000, 32'h3FC00000, 7'b1, 2'd3,
           48'h0, 10'd0, 2'b00);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(sbq.pop_back());
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_prod", 64'(bus.prod), 64'd0);
    check("arst_expsum", 64'(bus.expsum), 64'd0);
    check("arst_special", 64'(bus.special), 64'd0);
    check("arst_sign", 64'(bus.sign_o), 64'd0);
    check("arst_rm", 64'(bus.roundmode_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    launch(32'h3FC00000, 32'h40000000, 7'b0, 2'd2,
           48'h6000_0000_0000, 10'd128, 2'b00);
    wait_idle();

    // second start during MUL is ignored
    launch(32'h3F800000, 32'h3F800000, 7'b0, 2'd0,
           48'h4000_0000_0000, 10'd127, 2'b00);
    repeat (5) @(negedge clk);
    drive(32'h40400000, 32'h40A00000, 7'b0, 2'd1);
    bus.start = 1'b1;
    check("busy_mid", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("no_requeue", 64'(bus.busy), 64'd0);

    // start held high: re-accepted in the IDLE cycle after DONE
    @(negedge clk);
    drive(32'h3FC00000, 32'h3FC00000, 7'b0, 2'd1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    c1 = cyc;
    e.prod = 48'h9000_0000_0000;
    e.es = 10'd127;
    e.sp = 2'b00;
    e.sg = 1'b0;
    e.rm = 2'd1;
    e.dc = c1 + 24;
    sbq.push_back(e);
    @(negedge clk);
    drive(32'h40000000, 32'h40400000, 7'b1, 2'd3);
    e.prod = 48'h6000_0000_0000;
    e.es = 10'd129;
    e.sg = 1'b1;
    e.rm = 2'd3;
    e.dc = c1 + 26 + 24;
    sbq.push_back(e);
    repeat (26) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
